lcd_bus_arbiter: RTL and testbench
==================================

LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: idle cycles a granted requester may hold the bus without req before grant is revoked.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports req0/req1  in  1  requester i wants to write one LCD byte.
REQ-005 SHALL have ports addr0/addr1  in  1  requester i LCD address bit (0 = instruction, 1 = data).
REQ-006 SHALL have ports data0/data1  in  8  requester i write byte.
REQ-007 SHALL have ports last0/last1  in  1  marks final byte of requester i's message.
REQ-008 SHALL have ports ack0/ack1  out  1  one-cycle pulse: requester i's current byte accepted by slave.
REQ-009 SHALL have ports address  out  1, chipselect  out  1, byteenable  out  1, read  out  1, write  out  1, writedata  out  8  Avalon-MM master to the LCD controller slave.
REQ-010 SHALL have port waitrequest  in  1  Avalon-MM slave stall.
REQ-011 SHALL have port init_done  out  1  high once the power-up sequence has completed.

Function
REQ-012 SHALL implement FSM states INIT, IDLE, GRANT.
REQ-013 In INIT, SHALL issue the package's 3-entry LCD_INIT_SEQ (0x38, 0x0C, 0x01, address 0) in order, one write per entry.
- Each write is held until ~waitrequest.
- Move to IDLE on the cycle the third write is accepted; init_done rises the following cycle.
REQ-014 req0/req1 SHALL be ignored while in INIT; ack0/ack1 stay 0.
REQ-015 In IDLE with any req high, SHALL register a grant (gnt) and enter GRANT next cycle; no write is asserted in IDLE.
REQ-016 Arbitration SHALL be round-robin on whole messages.
- On simultaneous req0 and req1, grant the requester not served last.
- After reset, requester 0 wins the first tie.
REQ-017 In GRANT, write and chipselect SHALL equal req of the granted requester; address and writedata SHALL pass through that requester's addr/data.
- writedata = 0 whenever write = 0.
REQ-018 ack of the granted requester SHALL equal write & ~waitrequest (combinational); the other ack SHALL be 0.
REQ-019 A requester SHALL hold req/addr/data/last stable until its ack; the arbiter need not capture them.
REQ-020 Grant SHALL be held across bytes until an acked byte has last = 1.
- On that cycle: return to IDLE and record the granted index as last-served.
- The other requester can therefore be granted no sooner than 2 cycles after that ack.
REQ-021 In GRANT, an 8-bit idle counter SHALL:
- increment each cycle the granted req is low;
- clear when that req is high.
- On reaching TIMEOUT, return to IDLE and mark the requester last-served (abandoned message).
REQ-022 The ungranted requester's req SHALL have no effect on the bus until it is granted.
REQ-023 read SHALL be 0 and byteenable SHALL be 1 at all times.
REQ-024 Reset asserted mid-transfer SHALL immediately drop write/chipselect and restart in INIT; the interrupted byte is not re-issued.

Reset
REQ-025 While reset_n = 0: state = INIT, init index = 0, gnt = 0, last-served = 1, idle counter = 0.
- Outputs: write = chipselect = 0, address = 0, writedata = 0, ack0 = ack1 = 0, init_done = 0.
REQ-026 On reset_n release, the first init write SHALL be asserted in the first clock cycle after release.

Structure
REQ-027 LCD_INIT_SEQ, the arbiter state enum type and the LCD command constants SHALL live in lcd_inst_pkg.
REQ-028 SHALL be a single module with no sub-modules; the round-robin grant logic stays inline.

Verification
REQ-029 Reset, waitrequest = 0 -> writedata 0x38, 0x0C, 0x01 on 3 consecutive cycles, address = 0; init_done high the cycle after 0x01.
REQ-030 After init, req0 sends 0x41/0x42 (last on 0x42) while req1 sends 0x43 (last) -> bus shows 0x41, 0x42, then 0x43; ack0 pulses twice before ack1 pulses once.
REQ-031 req0 and req1 rise in the same cycle, twice in succession, single-byte messages -> grant order 0, 1, 0, 1.
REQ-032 waitrequest held high 5 cycles during a granted write of 0x55 -> write held 6 cycles with data stable; exactly one ack pulse, on the 6th cycle.
REQ-033 TIMEOUT = 4; requester 0 sends a non-last byte then drops req -> returns to IDLE after 4 idle cycles; pending req1 is granted next.
REQ-034 reset_n pulsed low during a GRANT write -> write = 0 in the same cycle; INIT sequence restarts at 0x38.

Source files
------------

// File: rtl/lcd_inst_pkg.sv
// Shared LCD command constants, power-up sequence, bus payload and arbiter state type.
package lcd_inst_pkg;

  localparam int unsigned LCD_DATA_W   = 8;
  localparam int unsigned LCD_INIT_LEN = 3;

  localparam logic [LCD_DATA_W-1:0] LCD_CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [LCD_DATA_W-1:0] LCD_CMD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [LCD_DATA_W-1:0] LCD_CMD_CLEAR    = 8'h01;

  localparam logic [LCD_INIT_LEN-1:0][LCD_DATA_W-1:0] LCD_INIT_SEQ =
    {LCD_CMD_CLEAR, LCD_CMD_DISP_ON, LCD_CMD_FUNC_SET};

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    GRANT
  } arb_state_e;

  typedef struct packed {
    logic                  address;
    logic [LCD_DATA_W-1:0] data;
  } lcd_wr_t;

  // Constant-index lookup keeps the out-of-range index explicit.
  function automatic logic [LCD_DATA_W-1:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_INIT_SEQ[0];
      2'd1:    return LCD_INIT_SEQ[1];
      2'd2:    return LCD_INIT_SEQ[2];
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_arbiter.sv
// Two-requester round-robin arbiter in front of an Avalon-MM LCD controller,
// which first plays the power-up command sequence.
module lcd_bus_arbiter
  import lcd_inst_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  addr0,
  input  logic                  addr1,
  input  logic [LCD_DATA_W-1:0] data0,
  input  logic [LCD_DATA_W-1:0] data1,
  input  logic                  last0,
  input  logic                  last1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  address,
  output logic                  chipselect,
  output logic                  byteenable,
  output logic                  read,
  output logic                  write,
  output logic [LCD_DATA_W-1:0] writedata,
  input  logic                  waitrequest,
  output logic                  init_done
);

  localparam int unsigned CNT_W = 8;

  arb_state_e       state, state_nxt;
  logic [1:0]       init_idx, init_idx_nxt;
  logic             gnt, gnt_nxt;
  logic             last_srv, last_srv_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
  logic             init_done_nxt;
  logic             sel_req, sel_last, accept;
  lcd_wr_t          sel_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      init_idx  <= '0;
      gnt       <= 1'b0;
      last_srv  <= 1'b1;
      idle_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_idx  <= init_idx_nxt;
      gnt       <= gnt_nxt;
      last_srv  <= last_srv_nxt;
      idle_cnt  <= idle_cnt_nxt;
      init_done <= init_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    init_idx_nxt  = init_idx;
    gnt_nxt       = gnt;
    last_srv_nxt  = last_srv;
    idle_cnt_nxt  = idle_cnt;
    init_done_nxt = init_done;
    write         = 1'b0;
    address       = 1'b0;
    writedata     = '0;
    ack0          = 1'b0;
    ack1          = 1'b0;
    accept        = 1'b0;
    sel_req       = gnt ? req1 : req0;
    sel_last      = gnt ? last1 : last0;
    sel_wr.address = gnt ? addr1 : addr0;
    sel_wr.data    = gnt ? data1 : data0;

    unique case (state)
      INIT: begin
        write     = 1'b1;
        writedata = init_byte(init_idx);
        if (!waitrequest) begin
          if (init_idx == 2'(LCD_INIT_LEN - 1)) begin
            state_nxt     = IDLE;
            init_idx_nxt  = '0;
            init_done_nxt = 1'b1;
          end else begin
            init_idx_nxt = init_idx + 2'd1;
          end
        end
      end

      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins.
          gnt_nxt      = (req0 && req1) ? ~last_srv : req1;
          idle_cnt_nxt = '0;
          state_nxt    = GRANT;
        end
      end

      GRANT: begin
        write     = sel_req;
        address   = sel_wr.address;
        writedata = sel_req ? sel_wr.data : '0;
        accept    = sel_req && !waitrequest;
        ack0      = accept && !gnt;
        ack1      = accept && gnt;
        idle_cnt_nxt = sel_req ? '0 : idle_cnt + CNT_W'(1);
        // Message ends on its last accepted byte, or is abandoned after TIMEOUT idle cycles.
        if ((accept && sel_last) || (!sel_req && idle_cnt == CNT_W'(TIMEOUT - 1))) begin
          state_nxt    = IDLE;
          last_srv_nxt = gnt;
          idle_cnt_nxt = '0;
        end
      end

      default: state_nxt = INIT;
    endcase

    // Reset must kill an in-flight write immediately, not at the next edge.
    if (!reset_n) begin
      write     = 1'b0;
      address   = 1'b0;
      writedata = '0;
      ack0      = 1'b0;
      ack1      = 1'b0;
    end
  end

  assign chipselect = write;
  assign read       = 1'b0;
  assign byteenable = 1'b1;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Scoreboard bench: message-level round-robin model predicts accepted bus bytes.
module tb_lcd_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0, req1, addr0, addr1, last0, last1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, address, chipselect, byteenable, read, write, init_done;
  logic [7:0] writedata;
  logic       waitrequest = 1'b0;

  logic       req_v[2];
  logic       addr_v[2];
  logic [7:0] data_v[2];
  logic       last_v[2];

  assign req0 = req_v[0];  assign req1 = req_v[1];
  assign addr0 = addr_v[0]; assign addr1 = addr_v[1];
  assign data0 = data_v[0]; assign data1 = data_v[1];
  assign last0 = last_v[0]; assign last1 = last_v[1];

  lcd_bus_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1), .last0(last0), .last1(last1),
    .ack0(ack0), .ack1(ack1),
    .address(address), .chipselect(chipselect), .byteenable(byteenable),
    .read(read), .write(write), .writedata(writedata),
    .waitrequest(waitrequest), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         who;
    logic       addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_chk  = 0;
  int         n_pass = 0;
  bit         mon_en = 1'b0;
  bit         wr_rand = 1'b0;
  bit         wr_force = 1'b0;
  int         ls = 1;              // model: requester served last
  logic [8:0] m_byte[2][4];        // {addr, data} per message byte
  int         m_len[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Waitrequest: random or forced, updated mid-cycle.
  initial forever begin
    @(posedge clk); #2;
    waitrequest = wr_rand ? ($urandom_range(0, 3) == 0) : wr_force;
  end

  // Monitor: every accepted byte must be the next predicted one.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (write && !waitrequest) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {23'd0, address, writedata}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("bus_addr", 32'(address), 32'(mon_e.addr));
          chk("bus_data", 32'(writedata), 32'(mon_e.data));
          chk("bus_ack", {30'd0, ack1, ack0}, (mon_e.who == 1) ? 32'd2 : 32'd1);
        end
      end else begin
        chk("ack_quiet", {30'd0, ack1, ack0}, 32'd0);
        if (!write) chk("wdata_quiet", 32'(writedata), 32'd0);
      end
    end
  end

  task automatic push_msg(input int who);
    exp_t e;
    for (int k = 0; k < m_len[who]; k++) begin
      e.who = who; e.addr = m_byte[who][k][8]; e.data = m_byte[who][k][7:0];
      exp_q.push_back(e);
    end
  endtask

  task automatic put(input int who, input int k, input bit on);
    req_v[who] = on;
    if (on) begin
      addr_v[who] = m_byte[who][k][8];
      data_v[who] = m_byte[who][k][7:0];
      last_v[who] = (k == m_len[who] - 1);
    end else begin
      last_v[who] = 1'b0;
    end
  endtask

  // Requester: holds each byte until its ack, then presents the next.
  task automatic drive_msg(input int who);
    int k = 0;
    int guard = 0;
    put(who, 0, 1'b1);
    while (k < m_len[who] && guard < 2000) begin
      @(negedge clk);
      guard++;
      if ((who == 0) ? ack0 : ack1) k++;
      @(posedge clk); #1;
      if (k < m_len[who]) put(who, k, 1'b1);
      else put(who, 0, 1'b0);
    end
    chk("drv_done", 32'(k), 32'(m_len[who]));
  endtask

  // Both enabled requesters raise req in the same IDLE cycle.
  task automatic run_round(input bit en0, input bit en1);
    int first;
    if (en0 && en1) first = (ls == 0) ? 1 : 0;
    else first = en0 ? 0 : 1;
    push_msg(first);
    if (en0 && en1) begin
      push_msg(1 - first);
      ls = 1 - first;
    end else begin
      ls = first;
    end
    fork
      begin if (en0) drive_msg(0); end
      begin if (en1) drive_msg(1); end
    join
  endtask

  task automatic check_init(input bit hold_req1);
    bit [7:0] seq[3];
    seq[0] = 8'h38; seq[1] = 8'h0C; seq[2] = 8'h01;
    if (hold_req1) begin
      req_v[1] = 1'b1; addr_v[1] = 1'b1; data_v[1] = 8'h99; last_v[1] = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("init_write", 32'(write), 32'd1);
      chk("init_cs", 32'(chipselect), 32'd1);
      chk("init_data", 32'(writedata), 32'(seq[i]));
      chk("init_addr", 32'(address), 32'd0);
      chk("init_done_low", 32'(init_done), 32'd0);
      chk("init_no_ack", {30'd0, ack1, ack0}, 32'd0);
    end
    req_v[1] = 1'b0; last_v[1] = 1'b0;
    @(negedge clk);
    chk("init_done_high", 32'(init_done), 32'd1);
    chk("idle_no_write", 32'(write), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 1'b0; addr_v[i] = 1'b0; data_v[i] = 8'h00; last_v[i] = 1'b0;
    end
    reset_n = 1'b0;
    #3;
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_cs", 32'(chipselect), 32'd0);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_wdata", 32'(writedata), 32'd0);
    chk("rst_ack", {30'd0, ack1, ack0}, 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_byteenable", 32'(byteenable), 32'd1);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    check_init(1'b1);
    mon_en = 1'b1;

    // Two-byte message from 0 contends with one-byte message from 1.
    @(posedge clk); #1;
    m_len[0] = 2; m_byte[0][0] = {1'b1, 8'h41}; m_byte[0][1] = {1'b1, 8'h42};
    m_len[1] = 1; m_byte[1][0] = {1'b1, 8'h43};
    run_round(1'b1, 1'b1);

    // Back-to-back single-byte ties alternate.
    for (int r = 0; r < 2; r++) begin
      m_len[0] = 1; m_byte[0][0] = {1'b0, 8'(8'hA0 + r)};
      m_len[1] = 1; m_byte[1][0] = {1'b1, 8'(8'hB0 + r)};
      run_round(1'b1, 1'b1);
    end

    // Randomized rounds with random stalls.
    wr_rand = 1'b1;
    for (int r = 0; r < 40; r++) begin
      bit e0, e1;
      e0 = 1'($urandom_range(0, 1));
      e1 = 1'($urandom_range(0, 1));
      if (!e0 && !e1) e0 = 1'b1;
      for (int w = 0; w < 2; w++) begin
        m_len[w] = $urandom_range(1, 3);
        for (int k = 0; k < 4; k++) m_byte[w][k] = 9'($urandom);
      end
      run_round(e0, e1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wr_rand = 1'b0;
    @(posedge clk); #1;

    // Stalled write: 5 cycles of waitrequest, then accept.
    wr_force = 1'b1;
    m_len[0] = 1; m_byte[0][0] = {1'b1, 8'h55};
    push_msg(0); ls = 0;
    put(0, 0, 1'b1);
    @(negedge clk);
    chk("stall_idle_write", 32'(write), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 5) wr_force = 1'b0;
      @(negedge clk);
      chk("stall_write", 32'(write), 32'd1);
      chk("stall_data", 32'(writedata), 32'h55);
      chk("stall_ack", 32'(ack0), (i == 5) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    put(0, 0, 1'b0);
    @(negedge clk);
    chk("stall_done", 32'(write), 32'd0);

    // Abandoned message: timeout after 4 idle cycles, pending req1 next.
    @(posedge clk); #1;
    m_len[0] = 2; m_byte[0][0] = {1'b0, 8'h11};
    m_len[1] = 1; m_byte[1][0] = {1'b1, 8'h22};
    push_msg(1);
    exp_q.push_front('{who: 0, addr: 1'b0, data: 8'h11});
    ls = 1;
    put(0, 0, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_first_ack", 32'(ack0), 32'd1);
    @(posedge clk); #1;
    put(0, 0, 1'b0);
    put(1, 0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("to_bus_quiet", 32'(write), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_req1_write", 32'(write), 32'd1);
    chk("to_req1_data", 32'(writedata), 32'h22);
    chk("to_req1_ack", 32'(ack1), 32'd1);
    @(posedge clk); #1;
    put(1, 0, 1'b0);

    // Reset in the middle of a stalled granted write.
    wr_force = 1'b1;
    m_len[0] = 1; m_byte[0][0] = {1'b1, 8'h77};
    put(0, 0, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_write", 32'(write), 32'd1);
    @(posedge clk); #3;
    mon_en = 1'b0;
    reset_n = 1'b0;
    wr_force = 1'b0;
    put(0, 0, 1'b0);
    #1;
    chk("midrst_write", 32'(write), 32'd0);
    chk("midrst_cs", 32'(chipselect), 32'd0);
    chk("midrst_wdata", 32'(writedata), 32'd0);
    chk("midrst_init_done", 32'(init_done), 32'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    ls = 1;
    check_init(1'b0);
    mon_en = 1'b1;

    // Tie after re-reset goes to requester 0 again.
    @(posedge clk); #1;
    m_len[0] = 1; m_byte[0][0] = {1'b1, 8'hC0};
    m_len[1] = 1; m_byte[1][0] = {1'b1, 8'hC1};
    run_round(1'b1, 1'b1);
    repeat (2) @(posedge clk);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
